// File: rtl/grp_buffer_wr_ctrl.sv
// Ping-pong group buffer write scheduler.
// Writes receiver payloads into the bank the frame former is not reading.
module grp_buffer_wr_ctrl #(
  parameter int          DEPTH    = 1024,
  parameter int          ADDR_W   = 10,
  parameter logic [3:0]  SYNC_TAG = 4'hF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       iWord,
  input  logic              iValid,
  input  logic              iSwitch,
  output logic [ADDR_W-1:0] oWrAddr,
  output logic [11:0]       oWrData,
  output logic              oWE0,
  output logic              oWE1,
  output logic              oWrBank,
  output logic [1:0]        oFilled,
  output logic [7:0]        oOvf,
  output logic [7:0]        oShort
);

  typedef enum logic [1:0] {
    HUNT,
    FILL,
    FULL
  } state_t;

  state_t            state, state_n, cur;
  logic [ADDR_W-1:0] addr, addr_n;
  logic              s1, s2, s3, swap;
  logic              bank_n, accept;
  logic [1:0]        filled_n;
  logic [7:0]        ovf_n, short_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [11:0]       wr_data_n;
  logic              we0_n, we1_n;

  assign swap = s2 ^ s3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      s3      <= 1'b0;
      state   <= HUNT;
      addr    <= '0;
      oWrBank <= 1'b1;
      oFilled <= 2'b00;
      oOvf    <= 8'd0;
      oShort  <= 8'd0;
      oWrAddr <= '0;
      oWrData <= 12'd0;
      oWE0    <= 1'b0;
      oWE1    <= 1'b0;
    end else begin
      s1      <= iSwitch;
      s2      <= s1;
      s3      <= s2;
      state   <= state_n;
      addr    <= addr_n;
      oWrBank <= bank_n;
      oFilled <= filled_n;
      oOvf    <= ovf_n;
      oShort  <= short_n;
      oWrAddr <= wr_addr_n;
      oWrData <= wr_data_n;
      oWE0    <= we0_n;
      oWE1    <= we1_n;
    end
  end

  always_comb begin
    cur       = state;
    state_n   = state;
    addr_n    = addr;
    bank_n    = oWrBank;
    filled_n  = oFilled;
    ovf_n     = oOvf;
    short_n   = oShort;
    wr_addr_n = oWrAddr;
    wr_data_n = oWrData;
    we0_n     = 1'b0;
    we1_n     = 1'b0;
    accept    = 1'b0;

    // A swap takes effect before any word arriving in the same cycle
    if (swap) begin
      cur              = HUNT;
      state_n          = HUNT;
      addr_n           = '0;
      bank_n           = ~s2;
      filled_n[~s2]    = 1'b0;
      if (state == FILL && oShort != 8'hFF)
        short_n = oShort + 8'd1;
    end

    if (iValid) begin
      unique case (cur)
        HUNT: begin
          if (iWord[15:12] == SYNC_TAG) begin
            addr_n = '0;
            accept = 1'b1;
          end
        end
        FILL: accept = 1'b1;
        FULL: begin
          if (oOvf != 8'hFF)
            ovf_n = oOvf + 8'd1;
        end
        default: ;
      endcase
    end

    if (accept) begin
      wr_addr_n = addr_n;
      wr_data_n = iWord[11:0];
      we0_n     = ~bank_n;
      we1_n     = bank_n;
      if (addr_n == ADDR_W'(DEPTH - 1)) begin
        state_n          = FULL;
        addr_n           = '0;
        filled_n[bank_n] = 1'b1;
      end else begin
        state_n = FILL;
        addr_n  = addr_n + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_grp_buffer_wr_ctrl.sv
// Bench for grp_buffer_wr_ctrl.
// Vector table plus scoreboard of expected buffer writes.
module tb_grp_buffer_wr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] iWord;
  logic        iValid;
  logic        iSwitch;
  logic [9:0]  oWrAddr;
  logic [11:0] oWrData;
  logic        oWE0, oWE1, oWrBank;
  logic [1:0]  oFilled;
  logic [7:0]  oOvf, oShort;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit exp_bank = 1'b1;

  typedef struct {
    bit        bank;
    bit [9:0]  addr;
    bit [11:0] data;
    int        cyc;
  } wr_t;
  wr_t q[$];

  typedef struct {
    logic [15:0] word;
    bit          wr;
    logic [9:0]  addr;
  } vec_t;

  grp_buffer_wr_ctrl dut (
    .clk(clk), .reset(reset), .iWord(iWord),
    .iValid(iValid), .iSwitch(iSwitch),
    .oWrAddr(oWrAddr), .oWrData(oWrData),
    .oWE0(oWE0), .oWE1(oWE1), .oWrBank(oWrBank),
    .oFilled(oFilled), .oOvf(oOvf), .oShort(oShort)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    checks++;
    if (oWE0 && oWE1) begin
      errors++;
      $display("FAIL we_both actual=11 required=not both");
    end
    if (q.size() > 0 && q[0].cyc < cyc) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL wr_missing addr=%0d required at cycle %0d", e.addr, e.cyc);
    end
    if (oWE0 || oWE1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected actual we1=%0b addr=%0d data=%0h required none",
                 oWE1, oWrAddr, oWrData);
      end else begin
        e = q.pop_front();
        if (oWE1 !== e.bank || oWrAddr !== e.addr ||
            oWrData !== e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL wr actual b%0b a%0d d%0h c%0d required b%0b a%0d d%0h c%0d",
                   oWE1, oWrAddr, oWrData, cyc,
                   e.bank, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic send(input logic [15:0] w, input bit wr,
                      input logic [9:0] a);
    if (wr) q.push_back('{exp_bank, a, w[11:0], cyc + 1});
    iWord  = w;
    iValid = 1'b1;
    @(negedge clk);
    iValid = 1'b0;
  endtask

  task automatic wait_bank(input bit b, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (oWrBank !== b && n < 8);
    chk(name, n, (n <= 3) ? n : 3);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_bank = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[3];
    tbl[0] = '{16'h1123, 1'b0, 10'd0};
    tbl[1] = '{16'hF456, 1'b1, 10'd0};
    tbl[2] = '{16'h0789, 1'b1, 10'd1};

    reset = 1'b0; iWord = '0; iValid = 1'b0; iSwitch = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_bank", oWrBank, 1);
    chk("rst_we", {oWE0, oWE1}, 0);
    chk("rst_filled", oFilled, 0);
    chk("rst_ovf", oOvf, 0);
    chk("rst_short", oShort, 0);
    chk("rst_addr", oWrAddr, 0);

    for (int i = 0; i < 3; i++)
      send(tbl[i].word, tbl[i].wr, tbl[i].addr);
    @(negedge clk);
    chk("tbl_drained", q.size(), 0);

    do_reset();
    send(16'hF000, 1'b1, 10'd0);
    for (int i = 1; i < 1024; i++)
      send({4'(i), 12'(i * 7)}, 1'b1, 10'(i));
    chk("full_filled", oFilled, 2'b10);
    chk("full_ovf0", oOvf, 0);
    send(16'hFABC, 1'b0, 10'd0);
    chk("ovf_one", oOvf, 1);
    for (int i = 0; i < 300; i++) send(16'h0555, 1'b0, 10'd0);
    chk("ovf_sat", oOvf, 255);

    iSwitch = 1'b1;
    wait_bank(1'b0, "swap_lat_full");
    chk("swap_bank0", oWrBank, 0);
    chk("swap_short0", oShort, 0);
    chk("swap_filled", oFilled, 2'b10);
    exp_bank = 1'b0;
    send(16'h2111, 1'b0, 10'd0);
    send(16'hF0AB, 1'b1, 10'd0);
    for (int i = 1; i < 10; i++)
      send(16'h1000 + 16'(i), 1'b1, 10'(i));

    iSwitch = 1'b0;
    wait_bank(1'b1, "swap_lat_part");
    chk("short_one", oShort, 1);
    chk("filled_clr", oFilled, 2'b00);
    exp_bank = 1'b1;
    send(16'hF321, 1'b1, 10'd0);
    send(16'hF322, 1'b1, 10'd1);

    iSwitch = 1'b1;
    repeat (2) @(negedge clk);
    exp_bank = 1'b0;
    send(16'hF5A5, 1'b1, 10'd0);
    chk("same_cyc_bank", oWrBank, 0);
    chk("short_two", oShort, 2);
    send(16'h0111, 1'b1, 10'd1);

    #2 reset = 1'b0;
    #1;
    chk("mid_rst_we", {oWE0, oWE1}, 0);
    chk("mid_rst_bank", oWrBank, 1);
    chk("mid_rst_cnt", {oOvf, oShort, 6'd0, oFilled}, 0);
    chk("mid_rst_addr", oWrAddr, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) send(16'hF777, 1'b0, 10'd0);
    reset = 1'b1;
    send(16'h0222, 1'b0, 10'd0);

    repeat (3) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
